// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with a sticky illegal_instr flag.
module multicycle_control_unit #(
    parameter int MEM_LATENCY = 0,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op_code,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic [3:0]            alu_flag,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state,
    output logic                  illegal_instr
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LINK     = 4'd12,
        LUI      = 4'd13,
        AUIPC    = 4'd14,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] wait_q;
    logic       mem_state;
    logic       wait_done;
    logic [3:0] alu_op;
    logic       branch_taken;

    // SUB is only selected by R-type; I-type funct7_5 is part of the immediate.
    function automatic logic [3:0] funct_op(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    assign wait_done = (wait_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= (mem_state && !wait_done) ? wait_q + 4'd1 : 4'd0;
        end
    end

    // Flags come from rs1 - rs2: {zero, negative, carry, overflow}.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = alu_flag[3];
            3'b001:  branch_taken = !alu_flag[3];
            3'b100:  branch_taken = alu_flag[2] ^ alu_flag[0];
            3'b101:  branch_taken = !(alu_flag[2] ^ alu_flag[0]);
            3'b110:  branch_taken = !alu_flag[1];
            3'b111:  branch_taken = alu_flag[1];
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op_code)
            OP_STORE:         imm_src = 3'b001;
            OP_BRANCH:        imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;

        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = wait_done;
                pc_write   = wait_done;
                if (wait_done) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op_code)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = TRAP;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op_code == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (wait_done) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (wait_done) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = funct_op(funct3, funct7_5, 1'b1);
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = funct_op(funct3, funct7_5, 1'b0);
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = ALU_SUB;
                pc_write  = branch_taken;
                state_d   = FETCH;
            end
            JAL: begin
                // Target already sits in alu_out from DECODE; ALU now forms old_pc+4 for ALUWB.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = LINK;
            end
            LINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = TRAP;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase

        // Reset aborts the current instruction without letting any write land.
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign alu_control = ALU_CTRL_W'(alu_op);
    assign state       = state_q;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_d == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q && !rst;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; three instances at MEM_LATENCY 0, 1 and 2 share the inputs.
module tb_multicycle_control_unit;

    logic       clk;
    logic [2:0] rst;
    logic [6:0] op_code;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [3:0] alu_flag;

    logic       pc_write      [3];
    logic       adr_src       [3];
    logic       mem_write     [3];
    logic       ir_write      [3];
    logic       reg_write     [3];
    logic [1:0] result_src    [3];
    logic [1:0] alu_src_a     [3];
    logic [1:0] alu_src_b     [3];
    logic [2:0] imm_src       [3];
    logic [3:0] alu_control   [3];
    logic [3:0] state         [3];
    logic       illegal_instr [3];

    int checks;
    int errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control_unit #(
            .MEM_LATENCY(g),
            .ALU_CTRL_W (4)
        ) dut (
            .clk          (clk),
            .rst          (rst[g]),
            .op_code      (op_code),
            .funct3       (funct3),
            .funct7_5     (funct7_5),
            .alu_flag     (alu_flag),
            .pc_write     (pc_write[g]),
            .adr_src      (adr_src[g]),
            .mem_write    (mem_write[g]),
            .ir_write     (ir_write[g]),
            .reg_write    (reg_write[g]),
            .result_src   (result_src[g]),
            .alu_src_a    (alu_src_a[g]),
            .alu_src_b    (alu_src_b[g]),
            .imm_src      (imm_src[g]),
            .alu_control  (alu_control[g]),
            .state        (state[g]),
            .illegal_instr(illegal_instr[g])
        );
    end

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Holds every instance in reset for two edges, then frees instance k; returns in its first FETCH cycle.
    task automatic release_dut(input int k);
        @(negedge clk);
        rst = 3'b111;
        repeat (2) @(negedge clk);
        rst[k] = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        op_code = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1; alu_flag = 4'b0000;
        rst = 3'b111;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state[0] !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state[0]); end
        checks++;
        if (pc_write[0] !== 1'b0) begin errors++; $display("FAIL reset_pc_write: got %0b expected 0", pc_write[0]); end
        checks++;
        if (ir_write[0] !== 1'b0) begin errors++; $display("FAIL reset_ir_write: got %0b expected 0", ir_write[0]); end
        checks++;
        if (reg_write[0] !== 1'b0 || mem_write[0] !== 1'b0) begin
            errors++; $display("FAIL reset_reg_mem_write: got %0b%0b expected 00", reg_write[0], mem_write[0]);
        end
        checks++;
        if (illegal_instr[0] !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0b expected 0", illegal_instr[0]); end
    endtask

    task automatic test_rtype_sub();
        int exp_s [5];
        exp_s = '{0, 1, 6, 8, 0};
        op_code = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        release_dut(0);
        checks++;
        if (ir_write[0] !== 1'b1 || pc_write[0] !== 1'b1) begin
            errors++; $display("FAIL rtype_fetch_writes: got ir=%0b pc=%0b expected 1 1", ir_write[0], pc_write[0]);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state[0] !== 4'(exp_s[i])) begin
                errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state[0], exp_s[i]);
            end
            checks++;
            if (reg_write[0] !== (exp_s[i] == 8)) begin
                errors++; $display("FAIL rtype_reg_write[%0d]: got %0b expected %0b", i, reg_write[0], exp_s[i] == 8);
            end
            if (i == 2) begin
                checks++;
                if (alu_control[0] !== 4'b0001) begin
                    errors++; $display("FAIL rtype_alu_control: got %b expected 0001", alu_control[0]);
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_itype_srai();
        op_code = 7'b0010011; funct3 = 3'b101; funct7_5 = 1'b1;
        release_dut(0);
        repeat (2) step();
        checks++;
        if (state[0] !== 4'd7 || alu_control[0] !== 4'b1001 || alu_src_b[0] !== 2'b01) begin
            errors++; $display("FAIL itype_srai: got state=%0d alu=%b b=%b expected 7 1001 01", state[0], alu_control[0], alu_src_b[0]);
        end
        funct3 = 3'b000;
        #1;
        checks++;
        if (alu_control[0] !== 4'b0000) begin
            errors++; $display("FAIL itype_addi_f7: got %b expected 0000", alu_control[0]);
        end
    endtask

    task automatic test_lw_latency();
        int exp_s   [10];
        logic exp_ir  [10];
        logic exp_adr [10];
        exp_s   = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
        exp_ir  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        exp_adr = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        op_code = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
        release_dut(2);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (state[2] !== 4'(exp_s[i])) begin
                errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state[2], exp_s[i]);
            end
            checks++;
            if (ir_write[2] !== exp_ir[i] || pc_write[2] !== exp_ir[i]) begin
                errors++; $display("FAIL lw_fetch_writes[%0d]: got ir=%0b pc=%0b expected %0b", i, ir_write[2], pc_write[2], exp_ir[i]);
            end
            checks++;
            if (adr_src[2] !== exp_adr[i]) begin
                errors++; $display("FAIL lw_adr_src[%0d]: got %0b expected %0b", i, adr_src[2], exp_adr[i]);
            end
            if (i == 8) begin
                checks++;
                if (reg_write[2] !== 1'b1 || result_src[2] !== 2'b01) begin
                    errors++; $display("FAIL lw_memwb: got reg_write=%0b result_src=%b expected 1 01", reg_write[2], result_src[2]);
                end
            end
            if (i < 9) step();
        end
    endtask

    task automatic test_branches();
        logic [2:0] f3_t   [7];
        logic [3:0] flag_t [7];
        logic       exp_t  [7];
        f3_t   = '{3'b100,  3'b111,  3'b000,  3'b001,  3'b110,  3'b101,  3'b010};
        flag_t = '{4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0101, 4'b1111};
        exp_t  = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
        op_code = 7'b1100011; funct7_5 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            funct3 = f3_t[i]; alu_flag = flag_t[i];
            release_dut(0);
            step();
            checks++;
            if (imm_src[0] !== 3'b010) begin
                errors++; $display("FAIL branch_imm_src[%0d]: got %b expected 010", i, imm_src[0]);
            end
            step();
            checks++;
            if (state[0] !== 4'd9 || alu_control[0] !== 4'b0001) begin
                errors++; $display("FAIL branch_state[%0d]: got state=%0d alu=%b expected 9 0001", i, state[0], alu_control[0]);
            end
            checks++;
            if (pc_write[0] !== exp_t[i]) begin
                errors++; $display("FAIL branch_taken[%0d]: got %0b expected %0b", i, pc_write[0], exp_t[i]);
            end
            step();
            checks++;
            if (state[0] !== 4'd0) begin
                errors++; $display("FAIL branch_return[%0d]: got %0d expected 0", i, state[0]);
            end
        end
        alu_flag = 4'b0000;
    endtask

    task automatic test_jalr();
        int exp_s [5];
        exp_s = '{0, 1, 11, 12, 0};
        op_code = 7'b1100111; funct3 = 3'b000;
        release_dut(0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state[0] !== 4'(exp_s[i])) begin
                errors++; $display("FAIL jalr_state[%0d]: got %0d expected %0d", i, state[0], exp_s[i]);
            end
            if (i == 2) begin
                checks++;
                if (pc_write[0] !== 1'b1 || result_src[0] !== 2'b10 || reg_write[0] !== 1'b0) begin
                    errors++; $display("FAIL jalr_jump: got pc=%0b res=%b reg=%0b expected 1 10 0", pc_write[0], result_src[0], reg_write[0]);
                end
            end
            if (i == 3) begin
                checks++;
                if (reg_write[0] !== 1'b1 || alu_src_a[0] !== 2'b01 || alu_src_b[0] !== 2'b10 || pc_write[0] !== 1'b0) begin
                    errors++; $display("FAIL jalr_link: got reg=%0b a=%b b=%b pc=%0b expected 1 01 10 0", reg_write[0], alu_src_a[0], alu_src_b[0], pc_write[0]);
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_lui();
        op_code = 7'b0110111;
        release_dut(0);
        step();
        checks++;
        if (imm_src[0] !== 3'b100) begin errors++; $display("FAIL lui_imm_src: got %b expected 100", imm_src[0]); end
        step();
        checks++;
        if (state[0] !== 4'd13 || reg_write[0] !== 1'b1 || alu_src_a[0] !== 2'b11 || result_src[0] !== 2'b10) begin
            errors++; $display("FAIL lui_exec: got state=%0d reg=%0b a=%b res=%b expected 13 1 11 10", state[0], reg_write[0], alu_src_a[0], result_src[0]);
        end
        step();
        checks++;
        if (state[0] !== 4'd0) begin errors++; $display("FAIL lui_return: got %0d expected 0", state[0]); end
    endtask

    task automatic test_store_reset();
        int   exp_s  [7];
        logic exp_mw [7];
        exp_s  = '{0, 0, 1, 2, 5, 5, 0};
        exp_mw = '{0, 0, 0, 0, 1, 1, 0};
        op_code = 7'b0100011; funct3 = 3'b010;
        release_dut(1);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (state[1] !== 4'(exp_s[i]) || mem_write[1] !== exp_mw[i]) begin
                errors++; $display("FAIL sw_seq[%0d]: got state=%0d mw=%0b expected %0d %0b", i, state[1], mem_write[1], exp_s[i], exp_mw[i]);
            end
            if (i < 6) step();
        end
        release_dut(1);
        repeat (3) step();
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        checks++;
        if (state[1] !== 4'd5 || mem_write[1] !== 1'b0) begin
            errors++; $display("FAIL sw_abort: got state=%0d mw=%0b expected 5 0", state[1], mem_write[1]);
        end
        step();
        checks++;
        if (state[1] !== 4'd0) begin errors++; $display("FAIL sw_abort_state: got %0d expected 0", state[1]); end
    endtask

    task automatic test_illegal();
        op_code = 7'b1111111; funct3 = 3'b000;
        release_dut(0);
        step();
        checks++;
        if (state[0] !== 4'd1 || illegal_instr[0] !== 1'b0) begin
            errors++; $display("FAIL illegal_decode: got state=%0d ill=%0b expected 1 0", state[0], illegal_instr[0]);
        end
        step();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (state[0] !== 4'd15 || illegal_instr[0] !== 1'b1) begin
                errors++; $display("FAIL trap_hold[%0d]: got state=%0d ill=%0b expected 15 1", i, state[0], illegal_instr[0]);
            end
            checks++;
            if ({pc_write[0], ir_write[0], reg_write[0], mem_write[0]} !== 4'b0000) begin
                errors++; $display("FAIL trap_writes[%0d]: got %b expected 0000", i,
                                   {pc_write[0], ir_write[0], reg_write[0], mem_write[0]});
            end
            step();
        end
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        checks++;
        if (illegal_instr[0] !== 1'b0) begin errors++; $display("FAIL trap_reset_ill: got %0b expected 0", illegal_instr[0]); end
        step();
        checks++;
        if (state[0] !== 4'd0) begin errors++; $display("FAIL trap_reset_state: got %0d expected 0", state[0]); end
`else
        checks++;
        if (state[0] !== 4'd0 || illegal_instr[0] !== 1'b0) begin
            errors++; $display("FAIL illegal_nop: got state=%0d ill=%0b expected 0 0", state[0], illegal_instr[0]);
        end
        step();
        checks++;
        if (state[0] !== 4'd1 || illegal_instr[0] !== 1'b0) begin
            errors++; $display("FAIL illegal_refetch: got state=%0d ill=%0b expected 1 0", state[0], illegal_instr[0]);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 3'b111;
        op_code  = 7'b0;
        funct3   = 3'b0;
        funct7_5 = 1'b0;
        alu_flag = 4'b0;
        test_reset();
        test_rtype_sub();
        test_itype_srai();
        test_lw_latency();
        test_branches();
        test_jalr();
        test_lui();
        test_store_reset();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM control unit for the multicycle RV32I core, the successor to the single-cycle decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback using a shared ALU and a single memory port.
- Parametrised memory wait states.
- Resolves branches in the BRANCH state from the ALU flags of an rs1-rs2 subtraction.

Parameters:
- MEM_LATENCY, 0: extra wait cycles per memory access (FETCH, MEMREAD, MEMWRITE); range 0..15.
- ALU_CTRL_W, 4: width of alu_control.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous reset, active-high
- op_code  input  7  instr[6:0] from the IR
- funct3  input  3  instr[14:12]
- funct7_5  input  1  instr[30]
- alu_flag  input  4  ALU flags {zero, negative, carry, overflow}; MSB is zero
- pc_write  output  1  PC load enable
- adr_src  output  1  memory address: 0 = PC, 1 = result
- mem_write  output  1  data memory write enable
- ir_write  output  1  IR and old_pc load enable
- reg_write  output  1  register file write enable
- result_src  output  2  00 = alu_out register, 01 = mem data register, 10 = direct ALU result
- alu_src_a  output  2  00 = PC, 01 = old_pc, 10 = rd1, 11 = zero
- alu_src_b  output  2  00 = rd2, 01 = imm_ext, 10 = constant 4
- imm_src  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U; combinational from op_code, I when unknown
- alu_control  output  ALU_CTRL_W  ALU operation code
- state  output  4  current state, for debug and verification
- illegal_instr  output  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LINK 12, LUI 13, AUIPC 14, TRAP 15.
- Reset:
  - while rst is high: pc_write, ir_write, reg_write and mem_write are forced to 0; illegal_instr is 0.
  - next state is FETCH and the wait counter is 0.
  - rst asserted mid-instruction aborts it; no write enable fires in that cycle.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
- Funct decode (EXECUTER and EXECUTEI), by funct3:
  - 000: ADD; SUB only for R-type with funct7_5 = 1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRA if funct7_5 = 1, else SRL.
  - 110: OR. 111: AND.
- Per-state outputs; signals not listed are 0, don't-care muxes are 00.
  - FETCH: adr_src=0, a=00, b=10, ADD, result_src=10. ir_write and pc_write fire only on the final wait cycle.
  - DECODE: a=01, b=01, ADD (branch/JAL target into alu_out).
    - Next state by op_code: 0000011 and 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC; other -> see Optional Feature.
  - MEMADR: a=10, b=01, ADD. Next: load -> MEMREAD, store -> MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
  - MEMWB: result_src=01, reg_write. Next: FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write on every cycle of the state. Next: FETCH.
  - EXECUTER: a=10, b=00, funct decode. Next: ALUWB.
  - EXECUTEI: a=10, b=01, funct decode. Next: ALUWB.
  - ALUWB: result_src=00, reg_write. Next: FETCH.
  - BRANCH: a=10, b=00, SUB, result_src=00. pc_write = taken, where:
    - beq: Z. bne: !Z.
    - blt: N^V. bge: !(N^V).
    - bltu: !C. bgeu: C.
    - funct3 010/011 is never taken.
    - Next: FETCH.
  - JAL: a=01, b=10, ADD, result_src=00, pc_write. Next: ALUWB (writes old_pc+4).
  - JALR: a=10, b=01, ADD, result_src=10, pc_write. Next: LINK.
  - LINK: a=01, b=10, ADD, result_src=10, reg_write. Next: FETCH.
  - LUI: a=11, b=01, ADD, result_src=10, reg_write. Next: FETCH.
  - AUIPC: a=01, b=01, ADD, result_src=10, reg_write. Next: FETCH.
- Wait counter:
  - FETCH, MEMREAD and MEMWRITE each hold for MEM_LATENCY+1 cycles.
  - The counter increments while in those states, clears on exit, and saturates at MEM_LATENCY.
  - MEM_LATENCY=0 gives single-cycle states.
- Cycle counts at MEM_LATENCY=0: R/I-type 4, lw 5, sw 4, branch 3, jal 4, jalr 4, lui/auipc 3.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op_code in DECODE goes to TRAP.
  - TRAP holds forever with all write enables 0, and illegal_instr is set (sticky) from the cycle TRAP is entered.
  - Only rst exits TRAP.
- Undefined:
  - An unknown op_code goes DECODE -> FETCH as a NOP.
  - illegal_instr is tied to 0 and TRAP is unreachable.

Test Plan:
- MEM_LATENCY=0, R-type sub (0110011, f3=000, f7_5=1) -> state sequence 0, 1, 6, 8, 0; alu_control=0001 in state 6; reg_write=1 only in state 8.
- MEM_LATENCY=2, lw (0000011) -> FETCH 3 cycles with ir_write/pc_write only on cycle 3; MEMREAD 3 cycles; 9 cycles total; reg_write=1 in MEMWB with result_src=01.
- Branches (1100011) in BRANCH:
  - blt with alu_flag=0100 -> pc_write=1.
  - bgeu with alu_flag=0000 -> pc_write=0.
  - beq with alu_flag=1000 -> pc_write=1.
- jalr (1100111) -> states 0, 1, 11, 12; pc_write=1 with result_src=10 in state 11; reg_write=1 with a=01, b=10 in state 12.
- MEM_LATENCY=1, rst asserted on the first MEMWRITE cycle -> mem_write=0 that cycle; state=0 on the next cycle.
- op_code 1111111:
  - with ILLEGAL_TRAP_EN -> state=15 and illegal_instr=1 held for 10 cycles with no write enables.
  - without it -> returns to FETCH, illegal_instr=0.
